// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: datapath width,
// PC increment and FSM state encodings.
package pc_seq_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: load-enabled, async active-low reset to a fixed value.
module pc_reg
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_d,
   output logic [31:0] o_q
);

   logic [XLEN-1:0] r_q;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_q <= RESET_VAL;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/execute controller owning the program counter;
// the PC only advances when the datapath reports completion.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [2:0]  state,
   output logic        misaligned
);

   state_t          r_state;
   logic [XLEN-1:0] r_instr;
   logic            r_misaligned;

   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_next;
   logic            w_pc_load;

   assign w_pc_plus4 = w_pc + XLEN'(PC_STEP);

   // Next-PC select: commit only on a completed, non-halting, aligned resolution
   always_comb begin
      w_pc_load = 1'b0;
      w_pc_next = w_pc_plus4;
      if (r_state == ST_EXEC && exec_done && !halt) begin
         if (!branch_taken) begin
            w_pc_load = 1'b1;
         end else if (is_word_aligned(branch_target)) begin
            w_pc_load = 1'b1;
            w_pc_next = branch_target;
         end
      end
   end

   pc_reg #(
      .RESET_VAL (RESET_ADDR)
   ) u_pc_reg (
      .CLK    (CLK),
      .reset  (reset),
      .i_load (w_pc_load),
      .i_d    (w_pc_next),
      .o_q    (w_pc)
   );

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_instr      <= '0;
         r_misaligned <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (exec_done) begin
                  if (halt) begin
                     r_state <= ST_HALT;
                  end else if (branch_taken && !is_word_aligned(branch_target)) begin
                     r_misaligned <= 1'b1;
                     r_state      <= ST_HALT;
                  end else begin
                     r_state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            // Unused encodings are treated as a terminal fault
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign imem_req    = (r_state == ST_FETCH);
   assign instr_valid = (r_state == ST_DECODE);
   assign imem_addr   = w_pc;
   assign pc          = w_pc;
   assign pc_plus4    = w_pc_plus4;
   assign instr       = r_instr;
   assign state       = r_state;
   assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized transaction-level bench for pc_sequencer against a PC-rule model.
module tb_pc_sequencer;

   localparam logic [31:0] RST = 32'h0000_0100;

   logic        CLK;
   logic        reset;
   logic        start;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        exec_done;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halt;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [2:0]  state;
   logic        misaligned;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_pc;
   logic        exp_mis;
   logic [31:0] exp_instr;

   pc_sequencer #(.RESET_ADDR(RST)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .start         (start),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .exec_done     (exec_done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt          (halt),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .state         (state),
      .misaligned    (misaligned)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      start         = 1'b0;
      imem_ready    = 1'b0;
      imem_rdata    = '0;
      exec_done     = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      halt          = 1'b0;
   endtask

   // Reset may be applied at any point; effects must be visible before the next edge
   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      #2;
      check("rst_async_req",   32'(imem_req), 32'd0);
      check("rst_async_pc",    pc,            RST);
      check("rst_async_state", 32'(state),    32'd0);
      @(posedge CLK);
      #1;
      reset     = 1'b1;
      exp_pc    = RST;
      exp_mis   = 1'b0;
      exp_instr = '0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("idle_state", 32'(state),       32'd0);
         check("idle_req",   32'(imem_req),    32'd0);
         check("idle_valid", 32'(instr_valid), 32'd0);
      end
      check("rst_instr", instr,            32'd0);
      check("rst_mis",   32'(misaligned),  32'd0);
      check("rst_pc",    pc,               RST);
      check("rst_pc4",   pc_plus4,         RST + 32'd4);
   endtask

   task automatic launch();
      start = 1'b1;
      step();
      start = 1'($urandom_range(0, 1));
      check("launch_req",  32'(imem_req), 32'd1);
      check("launch_addr", imem_addr,     exp_pc);
   endtask

   // One instruction: fetch stall k, exec stall d, then resolve with (h, b, tgt)
   task automatic run_instr(input int k, input int d, input logic h, input logic b,
                            input logic [31:0] tgt, output bit stopped);
      logic [31:0] rdata;
      logic [31:0] old_pc;
      stopped = 1'b0;
      for (int i = 0; i < k; i++) begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         exec_done  = 1'($urandom_range(0, 1));
         step();
         check("fetch_hold_req",  32'(imem_req), 32'd1);
         check("fetch_hold_addr", imem_addr,     exp_pc);
      end
      rdata      = $urandom;
      imem_ready = 1'b1;
      imem_rdata = rdata;
      exec_done  = 1'b0;
      step();
      exp_instr = rdata;
      check("dec_valid", 32'(instr_valid), 32'd1);
      check("dec_instr", instr,            exp_instr);
      check("dec_req",   32'(imem_req),    32'd0);
      check("dec_state", 32'(state),       32'd2);
      // Inputs during decode must be ignored
      imem_ready    = 1'($urandom_range(0, 1));
      imem_rdata    = $urandom;
      exec_done     = 1'($urandom_range(0, 1));
      halt          = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      step();
      check("exec_state", 32'(state),       32'd3);
      check("exec_valid", 32'(instr_valid), 32'd0);
      check("exec_pc",    pc,               exp_pc);
      for (int i = 0; i < d; i++) begin
         exec_done     = 1'b0;
         imem_ready    = 1'b1;
         halt          = 1'($urandom_range(0, 1));
         branch_taken  = 1'($urandom_range(0, 1));
         branch_target = $urandom;
         step();
         check("exec_wait_state", 32'(state), 32'd3);
         check("exec_wait_pc",    pc,         exp_pc);
         check("exec_wait_instr", instr,      exp_instr);
      end
      exec_done     = 1'b1;
      imem_ready    = 1'($urandom_range(0, 1));
      halt          = h;
      branch_taken  = b;
      branch_target = tgt;
      old_pc        = exp_pc;
      if (h) stopped = 1'b1;
      else if (b && (tgt % 32'd4) != 32'd0) begin
         stopped = 1'b1;
         exp_mis = 1'b1;
      end else if (b) exp_pc = tgt;
      else exp_pc = old_pc + 32'd4;
      step();
      exec_done    = 1'b0;
      halt         = 1'b0;
      branch_taken = 1'b0;
      if (stopped) begin
         for (int i = 0; i < 3; i++) begin
            check("halt_state", 32'(state),      32'd4);
            check("halt_req",   32'(imem_req),   32'd0);
            check("halt_pc",    pc,              old_pc);
            check("halt_mis",   32'(misaligned), 32'(exp_mis));
            check("halt_instr", instr,           exp_instr);
            start         = 1'b1;
            imem_ready    = 1'b1;
            exec_done     = 1'b1;
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            step();
         end
         idle_inputs();
      end else begin
         check("next_state", 32'(state),      32'd1);
         check("next_req",   32'(imem_req),   32'd1);
         check("next_addr",  imem_addr,       exp_pc);
         check("next_pc4",   pc_plus4,        exp_pc + 32'd4);
         check("next_mis",   32'(misaligned), 32'd0);
      end
   endtask

   initial begin
      bit stp;
      reset = 1'b1;
      idle_inputs();
      #3;
      do_reset();
      launch();

      // Back-to-back sequential: 0x100 -> 0x104 -> 0x108 -> 0x10C
      for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 1'b0, 32'h0, stp);
      check("seq_addr", imem_addr, 32'h0000_010C);
      // Long fetch stall then aligned branch
      run_instr(4, 0, 1'b0, 1'b1, 32'h0000_2000, stp);
      check("br_addr", imem_addr, 32'h0000_2000);
      // Wrap-around of the top word address
      run_instr(0, 2, 1'b0, 1'b1, 32'hFFFF_FFFC, stp);
      run_instr(1, 0, 1'b0, 1'b0, 32'h0, stp);
      check("wrap_addr", imem_addr, 32'h0000_0000);
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, stp);
      check("wrap_addr2", imem_addr, 32'h0000_0004);
      // Misaligned branch target halts with sticky flag
      run_instr(0, 1, 1'b0, 1'b1, 32'h0000_2002, stp);
      check("mis_stopped", 32'(stp), 32'd1);

      // Halt takes priority over a misaligned branch
      do_reset();
      launch();
      run_instr(0, 0, 1'b0, 1'b0, 32'h0, stp);
      run_instr(2, 1, 1'b1, 1'b1, 32'h0000_3003, stp);
      check("halt_pri_mis", 32'(misaligned), 32'd0);

      // Reset while a fetch request is outstanding
      do_reset();
      launch();
      imem_ready = 1'b0;
      step();
      do_reset();

      // Random programs
      for (int p = 0; p < 20; p++) begin
         do_reset();
         launch();
         for (int n = 0; n < 15; n++) begin
            int          sel;
            logic        h;
            logic        b;
            logic [31:0] tgt;
            sel = $urandom_range(0, 11);
            h   = (sel == 0);
            b   = (sel >= 6) || (sel == 0 && $urandom_range(0, 1) == 1);
            tgt = $urandom;
            if (sel != 1) tgt[1:0] = 2'b00;
            if (sel == 1) begin
               b = 1'b1;
               if (tgt[1:0] == 2'b00) tgt[0] = 1'b1;
            end
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), h, b, tgt, stp);
            if (stp) break;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle fetch/execute controller that owns the program counter and sequences its updates. It drives instruction-memory requests, latches each fetched instruction, and hands it to the datapath. It then commits the next PC (PC+4 or a branch target) only when the datapath reports completion. It replaces the free-running PC+4 loop with a controlled, stallable sequencer.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  level; leaves IDLE when sampled high
- imem_req  output  1  instruction fetch request, held until accepted
- imem_addr  output  32  fetch address, always equal to pc
- imem_ready  input  1  memory accepts request and returns data the same cycle
- imem_rdata  input  32  instruction word, valid when imem_ready=1
- instr  output  32  latched instruction
- instr_valid  output  1  one-cycle pulse: instr is new, datapath may begin execute
- exec_done  input  1  datapath finished current instruction
- branch_taken  input  1  sampled only with exec_done
- branch_target  input  32  sampled only with exec_done and branch_taken
- halt  input  1  sampled only with exec_done; stop after current instruction
- pc  output  32  current PC
- pc_plus4  output  32  pc + 4, combinational
- state  output  3  FSM state encoding, for debug
- misaligned  output  1  sticky; taken branch to non-word-aligned target

## Operation
States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4. Values 5–7 are unused and go to HALT.
- IDLE: all request outputs low. start=1 moves the FSM to FETCH.
- FETCH: imem_req=1. On imem_ready=1, instr <= imem_rdata and the FSM moves to DECODE. Otherwise it stays in FETCH with imem_req held high.
- DECODE: instr_valid=1 for this single cycle. The FSM moves to EXEC unconditionally.
- EXEC: the FSM waits for exec_done=1, then resolves in priority order:
  - halt=1: pc unchanged, go to HALT. branch inputs are ignored.
  - branch_taken=1 and branch_target[1:0]≠0: misaligned <= 1, pc unchanged, go to HALT.
  - branch_taken=1: pc <= branch_target, go to FETCH.
  - otherwise: pc <= pc + 4, go to FETCH.
- HALT: terminal. Outputs are frozen, imem_req=0. Only reset exits HALT.
- pc changes only on the EXEC→FETCH transition.
- PC arithmetic is unsigned 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- imem_ready outside FETCH, and exec_done outside EXEC, are ignored.
- Reset values: pc=RESET_ADDR, instr=0, instr_valid=0, imem_req=0, misaligned=0, state=IDLE.
- Reset assertion clears all registers immediately, without waiting for a clock edge, including mid-FETCH (imem_req drops at once) and in HALT.

## Timing
- start sampled high at edge N → imem_req=1 during cycle N+1.
- Minimum per-instruction time is 3 cycles (FETCH, DECODE, EXEC), with imem_ready and exec_done both high on first sample.
- imem_ready latency of k cycles extends FETCH by k cycles.
- instr_valid asserts exactly one cycle after the accepting FETCH edge.
- A new pc is visible on imem_addr in the cycle after exec_done is sampled. The new fetch request is issued in that same cycle.
- Outputs come directly from registers, except:
  - imem_req and instr_valid: decoded from state, Moore-style.
  - pc_plus4: combinational from pc.
- No output depends combinationally on any input.

## Structure
- Shared package pc_seq_pkg contains:
  - state localparams (ST_IDLE … ST_HALT)
  - PC_STEP = 4
  - XLEN = 32
- One sub-module, pc_reg: 32-bit register with load-enable and asynchronous active-low reset to a parameter value. It holds pc.
- The next-PC mux and FSM live in pc_sequencer.

## Test plan
- Reset with RESET_ADDR=32'h100, start=1, imem_ready and exec_done always 1, no branches → imem_addr sequence 0x100, 0x104, 0x108; instr_valid pulses every 3 cycles.
- imem_ready held low 4 cycles in first FETCH, imem_rdata=32'hDEAD_BEEF → imem_req stays high 5 cycles, instr=32'hDEADBEEF, pc unchanged until exec_done.
- Branch_taken=1, branch_target=32'h0000_2000 with exec_done → next imem_addr=0x2000; with target 32'h2002 → misaligned=1, state=HALT, imem_req=0, pc unchanged.
- halt=1 together with branch_taken=1 at exec_done → state=HALT, pc unchanged, misaligned=0.
- pc=32'hFFFF_FFFC, sequential completion → pc=32'h0, fetch continues.
- Reset asserted mid-FETCH with imem_req=1 → imem_req=0 and pc=RESET_ADDR before the next clock edge. After release the FSM stays in IDLE until start.
